// File: rtl/ps2_scan_sequencer_pkg.sv
// Scan-code constants, FSM states and key record type shared by the PS/2 sequencer.
package ps2_scan_sequencer_pkg;

  localparam int CODE_W = 8;

  localparam logic [CODE_W-1:0] SC_E0     = 8'hE0;
  localparam logic [CODE_W-1:0] SC_E1     = 8'hE1;
  localparam logic [CODE_W-1:0] SC_F0     = 8'hF0;
  localparam logic [CODE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] SC_CTRL   = 8'h14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic              ext;
    logic [CODE_W-1:0] code;
  } key_t;

  localparam key_t K_LSHIFT = '{ext: 1'b0, code: SC_LSHIFT};
  localparam key_t K_RSHIFT = '{ext: 1'b0, code: SC_RSHIFT};
  localparam key_t K_LCTRL  = '{ext: 1'b0, code: SC_CTRL};
  localparam key_t K_RCTRL  = '{ext: 1'b1, code: SC_CTRL};

  function automatic logic is_prefix(input logic [CODE_W-1:0] b);
    return (b == SC_E0) || (b == SC_E1) || (b == SC_F0);
  endfunction

endpackage

// File: rtl/ps2_scan_sequencer_if.sv
// FIFO-side pop handshake plus key-event output bundle of the PS/2 sequencer.
interface ps2_scan_sequencer_if #(parameter int CNT_W = 8);
  import ps2_scan_sequencer_pkg::*;

  logic              ready;
  logic [CODE_W-1:0] data;
  logic              overflow;
  logic              nextdata_n;
  logic              ev_valid;
  logic              ev_ack;
  logic [CODE_W-1:0] ev_code;
  logic              ev_ext;
  logic              ev_break;
  logic              ev_repeat;
  logic              shift_held;
  logic              ctrl_held;
  logic [CNT_W-1:0]  press_cnt;
  logic              ovf_flag;
  logic              ovf_clr;

  modport master (
    input  ready, data, overflow, ev_ack, ovf_clr,
    output nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
           shift_held, ctrl_held, press_cnt, ovf_flag
  );

  modport slave (
    output ready, data, overflow, ev_ack, ovf_clr,
    input  nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
           shift_held, ctrl_held, press_cnt, ovf_flag
  );

endinterface

// File: rtl/ps2_scan_sequencer_mod_tracker.sv
// Per-key Shift/Ctrl held bits, updated on each final key event; left/right OR'd to outputs.
module ps2_mod_tracker
  import ps2_scan_sequencer_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic i_upd,
  input  key_t i_key,
  input  logic i_brk,
  output logic o_shift_held,
  output logic o_ctrl_held
);

  logic r_lshift, r_rshift, r_lctrl, r_rctrl;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_lctrl  <= 1'b0;
      r_rctrl  <= 1'b0;
    end else if (i_upd) begin
      if (i_key == K_LSHIFT) r_lshift <= !i_brk;
      if (i_key == K_RSHIFT) r_rshift <= !i_brk;
      if (i_key == K_LCTRL)  r_lctrl  <= !i_brk;
      if (i_key == K_RCTRL)  r_rctrl  <= !i_brk;
    end
  end

  assign o_shift_held = r_lshift | r_rshift;
  assign o_ctrl_held  = r_lctrl  | r_rctrl;

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Drains ps2_keyboard FIFO (<=1 byte/3 clk, pop strobe 1 clk after capture) into folded key events.
// Event is held until ev_ack; while an unacked event is pending no byte is popped.
module ps2_scan_sequencer
  import ps2_scan_sequencer_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PAUSE_SKIP = 7
) (
  input logic                  clk,
  input logic                  clrn,
  ps2_scan_sequencer_if.master bus
);

  localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

  state_t            r_state, w_state_nxt;
  logic              w_nextdata_n;
  logic              w_take, w_skipping, w_final, w_match, w_rep;
  key_t              w_key, r_rec;
  logic              r_ext_pend, r_brk_pend, r_held;
  logic [SKIP_W-1:0] r_skip;
  logic              r_ev_valid, r_ev_ext, r_ev_break, r_ev_repeat, r_ovf;
  logic [CODE_W-1:0] r_ev_code;
  logic [CNT_W-1:0]  r_press_cnt;

  // A byte is taken only when the event slot is free or being freed this cycle.
  assign w_take     = (r_state == S_IDLE) && bus.ready && (!r_ev_valid || bus.ev_ack);
  assign w_skipping = (r_skip != '0);
  assign w_final    = w_take && !w_skipping && !is_prefix(bus.data);
  assign w_key      = '{ext: r_ext_pend, code: bus.data};
  assign w_match    = r_held && (r_rec == w_key);
  assign w_rep      = !r_brk_pend && w_match;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_nextdata_n = 1'b1;
    unique case (r_state)
      S_IDLE: if (w_take) w_state_nxt = S_POP;
      S_POP: begin
        w_nextdata_n = 1'b0;
        w_state_nxt  = S_GAP;
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_skip     <= '0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_take) begin
      if (w_skipping) begin
        r_skip <= r_skip - 1'b1;
      end else if (bus.data == SC_E1) begin
        r_skip     <= SKIP_W'(PAUSE_SKIP);
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (bus.data == SC_E0) begin
        r_ext_pend <= 1'b1;
      end else if (bus.data == SC_F0) begin
        r_brk_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ev_valid  <= 1'b0;
      r_ev_code   <= '0;
      r_ev_ext    <= 1'b0;
      r_ev_break  <= 1'b0;
      r_ev_repeat <= 1'b0;
    end else if (w_final) begin
      r_ev_valid  <= 1'b1;
      r_ev_code   <= bus.data;
      r_ev_ext    <= r_ext_pend;
      r_ev_break  <= r_brk_pend;
      r_ev_repeat <= w_rep;
    end else if (bus.ev_ack) begin
      r_ev_valid  <= 1'b0;
    end
  end

  // Only the most recent make is remembered, so typematic detection covers one key.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rec       <= '0;
      r_held      <= 1'b0;
      r_press_cnt <= '0;
    end else if (w_final) begin
      if (r_brk_pend) begin
        if (w_match) r_held <= 1'b0;
      end else if (!w_rep) begin
        r_rec       <= w_key;
        r_held      <= 1'b1;
        r_press_cnt <= r_press_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)             r_ovf <= 1'b0;
    else if (bus.overflow) r_ovf <= 1'b1;
    else if (bus.ovf_clr)  r_ovf <= 1'b0;
  end

  ps2_mod_tracker u_mod_tracker (
    .clk          (clk),
    .clrn         (clrn),
    .i_upd        (w_final),
    .i_key        (w_key),
    .i_brk        (r_brk_pend),
    .o_shift_held (bus.shift_held),
    .o_ctrl_held  (bus.ctrl_held)
  );

  assign bus.nextdata_n = w_nextdata_n;
  assign bus.ev_valid   = r_ev_valid;
  assign bus.ev_code    = r_ev_code;
  assign bus.ev_ext     = r_ev_ext;
  assign bus.ev_break   = r_ev_break;
  assign bus.ev_repeat  = r_ev_repeat;
  assign bus.press_cnt  = r_press_cnt;
  assign bus.ovf_flag   = r_ovf;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: queue-backed FIFO stand-in, byte-stream reference model, directed + random steps.
module tb_ps2_scan_sequencer;
  import ps2_scan_sequencer_pkg::*;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  ps2_scan_sequencer_if #(.CNT_W(8)) bus ();

  ps2_scan_sequencer #(.CNT_W(8), .PAUSE_SKIP(7)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] code;
    logic       ext, brk, rep, sh, ct;
    logic [7:0] cnt;
  } ev_t;

  logic [7:0]  fifo[$];
  ev_t         exp_q[$];
  logic [10:0] acc_log[$];   // {ext, brk, rep, code} of accepted events
  int          errors = 0, checks = 0, pop_cnt = 0, acc_cnt = 0;
  bit          prev_low = 1'b0;

  // Reference model state: keyboard-level view of the byte stream
  int          m_skip;
  bit          m_ext, m_brk, m_held;
  logic [8:0]  m_rec;
  bit          m_down [0:511];
  logic [7:0]  m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_skip = 0; m_ext = 0; m_brk = 0; m_held = 0; m_rec = '0; m_cnt = '0;
    foreach (m_down[i]) m_down[i] = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    logic [8:0] key;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      key   = {m_ext, b};
      e.rep = !m_brk && m_held && (m_rec == key);
      if (m_brk) begin
        if (m_held && m_rec == key) m_held = 0;
      end else if (!e.rep) begin
        m_rec = key; m_held = 1; m_cnt = m_cnt + 8'd1;
      end
      m_down[key] = !m_brk;
      e.code = b; e.ext = m_ext; e.brk = m_brk; e.cnt = m_cnt;
      e.sh = m_down[9'h012] | m_down[9'h059];
      e.ct = m_down[9'h014] | m_down[9'h114];
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  // FIFO stand-in, pop observer and event scoreboard, all away from the active edge
  always @(negedge clk) begin
    ev_t e;
    if (!clrn) begin
      model_reset();
      exp_q.delete();
      prev_low = 1'b0;
    end else begin
      if (!bus.nextdata_n) begin
        chk("pop_single_cycle", 32'(prev_low), 0);
        chk("pop_nonempty", 32'(fifo.size() != 0), 1);
        if (fifo.size() != 0) begin
          model_byte(fifo[0]);
          void'(fifo.pop_front());
          pop_cnt++;
        end
      end
      prev_low = !bus.nextdata_n;
      if (bus.ev_valid && bus.ev_ack) begin
        chk("ev_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ev_code",   bus.ev_code,    e.code);
          chk("ev_ext",    bus.ev_ext,     e.ext);
          chk("ev_break",  bus.ev_break,   e.brk);
          chk("ev_repeat", bus.ev_repeat,  e.rep);
          chk("shift",     bus.shift_held, e.sh);
          chk("ctrl",      bus.ctrl_held,  e.ct);
          chk("press_cnt", bus.press_cnt,  e.cnt);
          acc_cnt++;
          acc_log.push_back({bus.ev_ext, bus.ev_break, bus.ev_repeat, bus.ev_code});
        end
      end
    end
    bus.ready = (fifo.size() != 0);
    bus.data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.ev_ack = 1'b1;
    while ((fifo.size() != 0 || bus.ev_valid || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({tag, "_drain"}, 32'(n < 2000), 1);
  endtask

  logic [8:0] keys [8] = '{9'h01C, 9'h032, 9'h012, 9'h059, 9'h014, 9'h114, 9'h175, 9'h021};

  initial begin
    int p0, a0, n;
    clrn = 1'b0;
    bus.ev_ack = 1'b0; bus.overflow = 1'b0; bus.ovf_clr = 1'b0;
    repeat (3) tick();
    chk("rst_nextdata_n", bus.nextdata_n, 1);
    chk("rst_ev_valid",   bus.ev_valid,   0);
    chk("rst_ev_code",    bus.ev_code,    0);
    chk("rst_press_cnt",  bus.press_cnt,  0);
    chk("rst_shift",      bus.shift_held, 0);
    chk("rst_ctrl",       bus.ctrl_held,  0);
    chk("rst_ovf",        bus.ovf_flag,   0);
    clrn = 1'b1;
    tick();

    // Single make
    push(8'h1C);
    drain("make1");
    chk("make1_pops", pop_cnt, 1);
    chk("make1_events", acc_cnt, 1);
    chk("make1_cnt", bus.press_cnt, 1);

    // Break folds F0 into one event
    push(8'hF0); push(8'h1C);
    drain("brk1");
    chk("brk1_pops", pop_cnt, 3);
    chk("brk1_events", acc_cnt, 2);
    chk("brk1_flag", acc_log[$][9], 1);

    // Typematic repeats
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain("rep");
    chk("rep_0", acc_log[$-3][9:8], 2'b00);
    chk("rep_1", acc_log[$-2][9:8], 2'b01);
    chk("rep_2", acc_log[$-1][9:8], 2'b01);
    chk("rep_brk", acc_log[$][9:8], 2'b10);
    chk("rep_cnt", bus.press_cnt, 2);

    // Modifiers
    push(8'hE0); push(8'h14);
    drain("rctrl_mk");
    chk("rctrl_mk_held", bus.ctrl_held, 1);
    chk("rctrl_mk_ext", acc_log[$][10], 1);
    push(8'hE0); push(8'hF0); push(8'h14);
    drain("rctrl_br");
    chk("rctrl_br_held", bus.ctrl_held, 0);
    chk("rctrl_br_extbrk", acc_log[$][10:9], 2'b11);
    push(8'h12); push(8'h59); push(8'hF0); push(8'h12);
    drain("shift");
    chk("shift_still_held", bus.shift_held, 1);
    push(8'hF0); push(8'h59);
    drain("shift_rel");
    chk("shift_released", bus.shift_held, 0);

    // Backpressure: one event held, no further pops, then back-to-back on ack
    p0 = pop_cnt;
    bus.ev_ack = 1'b0;
    push(8'h1C); push(8'h32); push(8'h21);
    repeat (20) tick();
    chk("bp_pops", pop_cnt - p0, 1);
    chk("bp_valid", bus.ev_valid, 1);
    chk("bp_code", bus.ev_code, 8'h1C);
    chk("bp_no_pop", bus.nextdata_n, 1);
    bus.ev_ack = 1'b1;
    tick();
    chk("bp_b2b_valid", bus.ev_valid, 1);
    chk("bp_b2b_code", bus.ev_code, 8'h32);
    drain("bp");

    // Pause sequence is swallowed
    a0 = acc_cnt;
    foreach (keys[i]) begin end
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
    push(8'hF0); push(8'h14); push(8'hF0); push(8'h77); push(8'h1C);
    drain("pause");
    chk("pause_events", acc_cnt - a0, 1);
    chk("pause_code", acc_log[$][7:0], 8'h1C);

    // Sticky overflow, set wins over clear
    bus.overflow = 1'b1; tick(); bus.overflow = 1'b0;
    chk("ovf_set", bus.ovf_flag, 1);
    bus.overflow = 1'b1; bus.ovf_clr = 1'b1; tick();
    bus.overflow = 1'b0; bus.ovf_clr = 1'b0;
    chk("ovf_set_wins", bus.ovf_flag, 1);
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    chk("ovf_clr", bus.ovf_flag, 0);

    // Random token stream with random ack
    for (int t = 0; t < 150; t++) begin
      logic [8:0] key;
      bit brk;
      key = keys[$urandom_range(0, 7)];
      if ($urandom_range(0, 24) == 0) begin
        push(8'hE1);
        repeat (7) push(8'($urandom_range(0, 255)));
      end
      brk = ($urandom_range(0, 2) == 0);
      if (brk && key[8] && $urandom_range(0, 1) == 1) begin
        push(8'hF0); push(8'hE0);
      end else begin
        if (key[8]) push(8'hE0);
        if (brk) push(8'hF0);
      end
      if (key[8] && $urandom_range(0, 5) == 0) push(8'hE0);
      if (brk && $urandom_range(0, 5) == 0) push(8'hF0);
      push(key[7:0]);
      repeat ($urandom_range(1, 8)) begin
        bus.ev_ack = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    drain("random");

    // Reset while the pop strobe is active
    bus.overflow = 1'b1; tick(); bus.overflow = 1'b0;
    push(8'h1C);
    n = 0;
    while (bus.nextdata_n && n < 50) begin tick(); n++; end
    chk("mid_pop_reached", bus.nextdata_n, 0);
    clrn = 1'b0;
    fifo.delete();
    #1;
    chk("mid_rst_nextdata_n", bus.nextdata_n, 1);
    chk("mid_rst_ev_valid",   bus.ev_valid,   0);
    chk("mid_rst_ev_code",    bus.ev_code,    0);
    chk("mid_rst_press_cnt",  bus.press_cnt,  0);
    chk("mid_rst_shift",      bus.shift_held, 0);
    chk("mid_rst_ctrl",       bus.ctrl_held,  0);
    chk("mid_rst_ovf",        bus.ovf_flag,   0);
    repeat (2) tick();
    clrn = 1'b1;
    tick();
    push(8'h1C);
    drain("post_rst");
    chk("post_rst_cnt", bus.press_cnt, 1);
    chk("post_rst_rep", acc_log[$][8], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
